sdram_bist: RTL and testbench

- Bus initiator for the SDRAM controller's CPU-side interface: word address, UDS/LDS strobes, oe/we requests and active-high dtack.
- Drives the same cycle the 68k CPU produces, muxed in place of the CPU during self-test.
- Writes address-derived patterns over a configurable window, reads them back and compares.
- Reports pass/fail and the first failing location and data.

---
 rtl/sdram_bist_if.sv | 30 +++
 rtl/sdram_bist.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sdram_bist.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_bist_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_bist_if
// Description : CPU-side SDRAM controller bus. It carries the 68k-style
//               word address, UDS/LDS strobes, oe/we requests and dtack.
//               The master modport is the initiator and the slave modport is
//               the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_bist_if;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_uds;
    logic        mem_lds;
    logic        mem_oe;
    logic        mem_we;
    logic        mem_dtack;

    modport master (
        output mem_addr, mem_wdata, mem_uds, mem_lds, mem_oe, mem_we,
        input  mem_rdata, mem_dtack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_uds, mem_lds, mem_oe, mem_we,
        output mem_rdata, mem_dtack
    );
endinterface
`default_nettype wire

// File: rtl/sdram_bist.sv
`default_nettype none
// ============================================================================
// Module      : sdram_bist
// Description : SDRAM self-test bus initiator. It runs four passes in order:
//               write P(a), read/check P(a), write ~P(a), read/check ~P(a).
//               Each pass walks 2**LEN_LOG2 words upward from BASE. It counts
//               mismatches and latches the first failing address and data.
//               Optional macro SDRAM_BIST_BYTE_LANE_EN adds a fifth pass. For
//               each word it writes 8'hA5 through UDS only, then 8'h5A through
//               LDS only, then reads the word back and expects 16'hA55A.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_bist #(
    parameter logic [23:0] BASE          = 24'h000000,
    parameter int          LEN_LOG2      = 10,
    parameter int          MIN_READ_WAIT = 16,
    parameter int          DATA_DELAY    = 2,
    parameter int          WRITE_HOLD    = 4,
    parameter int          GAP           = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [23:0]      err_addr,
    output logic [15:0]      err_data,
    output logic [15:0]      err_exp,
    sdram_bist_if.master     mem
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        W_REQ  = 4'd1,
        W_STB  = 4'd2,
        GAP_S  = 4'd3,
        R_REQ  = 4'd4,
        R_MIN  = 4'd5,
        R_ACK  = 4'd6,
        R_DLY  = 4'd7,
        CHECK  = 4'd8,
        DONE   = 4'd9
    } state_t;

    // Pass sequence: bit 0 selects read (1) or write (0), bit 1 selects the
    // inverted pattern, and value 4 is the byte-lane pass.
`ifdef SDRAM_BIST_BYTE_LANE_EN
    localparam logic [2:0]  SEQ_BYTE  = 3'd4;
    localparam logic [2:0]  SEQ_LAST  = 3'd4;
`else
    localparam logic [2:0]  SEQ_LAST  = 3'd3;
`endif
    localparam logic [15:0] HOLD_LAST = 16'(WRITE_HOLD - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);
    localparam logic [15:0] MIN_LAST  = 16'(MIN_READ_WAIT - 1);
    localparam logic [15:0] DLY_LAST  = 16'(DATA_DELAY - 1);

    state_t                state, state_n;
    logic [15:0]           cnt, cnt_n;
    logic [LEN_LOG2-1:0]   index, index_n, index_inc;
    logic [2:0]            seq, seq_n;
    logic                  pass_r, pass_n;
    logic [15:0]           errc_n;
    logic [23:0]           erra_n;
    logic [15:0]           errd_n, erre_n;
`ifdef SDRAM_BIST_BYTE_LANE_EN
    logic [1:0]            step, step_n;
`endif

    logic [23:0]           addr;
    logic [15:0]           pattern;
    logic [15:0]           expect_word;
    logic                  wr_uds, wr_lds;

    assign addr      = BASE + 24'(index);
    assign pattern   = addr[15:0] ^ {8'h00, addr[23:16]};
    assign index_inc = index + LEN_LOG2'(1);

    // Expected word for the current access; it is also the write data.
    always_comb begin
        expect_word = seq[1] ? ~pattern : pattern;
        wr_uds      = 1'b1;
        wr_lds      = 1'b1;
`ifdef SDRAM_BIST_BYTE_LANE_EN
        if (seq == SEQ_BYTE) begin
            case (step)
                2'd0:    expect_word = 16'hA500;
                2'd1:    expect_word = 16'h005A;
                default: expect_word = 16'hA55A;
            endcase
            wr_uds = (step == 2'd0);
            wr_lds = (step == 2'd1);
        end
`endif
    end

    // Registered state, counters and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            index     <= '0;
            seq       <= '0;
            pass_r    <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
            err_data  <= '0;
            err_exp   <= '0;
`ifdef SDRAM_BIST_BYTE_LANE_EN
            step      <= '0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            index     <= index_n;
            seq       <= seq_n;
            pass_r    <= pass_n;
            err_count <= errc_n;
            err_addr  <= erra_n;
            err_data  <= errd_n;
            err_exp   <= erre_n;
`ifdef SDRAM_BIST_BYTE_LANE_EN
            step      <= step_n;
`endif
        end
    end

    // Next-state logic: pass sequencing, per-access timing and result checks.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        index_n = index;
        seq_n   = seq;
        pass_n  = pass_r;
        errc_n  = err_count;
        erra_n  = err_addr;
        errd_n  = err_data;
        erre_n  = err_exp;
`ifdef SDRAM_BIST_BYTE_LANE_EN
        step_n  = step;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = W_REQ;
                    cnt_n   = '0;
                    index_n = '0;
                    seq_n   = '0;
                    pass_n  = 1'b0;
                    errc_n  = '0;
                    erra_n  = '0;
                    errd_n  = '0;
                    erre_n  = '0;
`ifdef SDRAM_BIST_BYTE_LANE_EN
                    step_n  = '0;
`endif
                end
            end
            W_REQ: begin
                state_n = W_STB;
                cnt_n   = '0;
            end
            W_STB: begin
                // Writes are posted, so they end after a fixed strobe time.
                if (cnt == HOLD_LAST) begin
                    state_n = GAP_S;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            GAP_S: begin
                if (cnt != GAP_LAST) begin
                    cnt_n = cnt + 16'd1;
                end else begin
                    cnt_n = '0;
`ifdef SDRAM_BIST_BYTE_LANE_EN
                    if (seq == SEQ_BYTE && step != 2'd2) begin
                        step_n  = step + 2'd1;
                        state_n = (step == 2'd0) ? W_REQ : R_REQ;
                    end else begin
                        step_n  = '0;
`else
                    begin
`endif
                        index_n = index_inc;
                        if (index_inc != '0) begin
                            state_n = seq[0] ? R_REQ : W_REQ;
                        end else if (seq == SEQ_LAST) begin
                            state_n = DONE;
                            pass_n  = (err_count == 16'd0);
                        end else begin
                            seq_n   = seq + 3'd1;
                            state_n = seq[0] ? W_REQ : R_REQ;
                        end
                    end
                end
            end
            R_REQ: begin
                state_n = R_MIN;
                cnt_n   = '0;
            end
            R_MIN: begin
                // dtack may be stale or belong to a refresh during this window.
                if (cnt == MIN_LAST) begin
                    state_n = R_ACK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            R_ACK: begin
                if (mem.mem_dtack) begin
                    state_n = (DATA_DELAY == 0) ? CHECK : R_DLY;
                    cnt_n   = '0;
                end
            end
            R_DLY: begin
                if (cnt == DLY_LAST) begin
                    state_n = CHECK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            CHECK: begin
                state_n = GAP_S;
                cnt_n   = '0;
                if (mem.mem_rdata != expect_word) begin
                    if (err_count == 16'd0) begin
                        erra_n = addr;
                        errd_n = mem.mem_rdata;
                        erre_n = expect_word;
                    end
                    if (err_count != 16'hFFFF) begin
                        errc_n = err_count + 16'd1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Bus and status outputs decoded from the current state.
    always_comb begin
        mem.mem_addr  = addr;
        mem.mem_we    = (state == W_REQ) || (state == W_STB);
        mem.mem_oe    = (state == R_REQ) || (state == R_MIN) || (state == R_ACK) ||
                        (state == R_DLY) || (state == CHECK);
        mem.mem_uds   = mem.mem_oe || ((state == W_STB) && wr_uds);
        mem.mem_lds   = mem.mem_oe || ((state == W_STB) && wr_lds);
        mem.mem_wdata = mem.mem_we ? expect_word : 16'h0000;
        busy          = (state != IDLE) && (state != DONE);
        done          = (state == DONE);
        pass          = pass_r;
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_bist
// Description : Bench for sdram_bist. A randomized SDRAM controller responder
//               feeds the DUT, and a transaction scoreboard checks every bus
//               access and the final result registers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_bist;
    localparam logic [23:0] BASE          = 24'h01FFFA;
    localparam int          LEN_LOG2      = 4;
    localparam int          N             = 1 << LEN_LOG2;
    localparam int          MIN_READ_WAIT = 16;
    localparam int          DATA_DELAY    = 2;
    localparam int          WRITE_HOLD    = 4;
    localparam int          GAP           = 8;
    localparam logic [23:0] FAULT_ADDR    = 24'h020000;

    typedef struct {
        bit          is_read;
        logic [23:0] addr;
        logic [15:0] data;
        bit          uds;
        bit          lds;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_count, err_data, err_exp;
    logic [23:0] err_addr;

    sdram_bist_if mem_bus ();

    sdram_bist #(
        .BASE(BASE), .LEN_LOG2(LEN_LOG2), .MIN_READ_WAIT(MIN_READ_WAIT),
        .DATA_DELAY(DATA_DELAY), .WRITE_HOLD(WRITE_HOLD), .GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .err_addr(err_addr),
        .err_data(err_data), .err_exp(err_exp), .mem(mem_bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- responder (controller + SDRAM) ----------------
    logic [15:0] mem_arr [N];
    bit refresh_mode = 0, slow_ack = 0, fault_en = 0;
    int oe_cnt = 0, ack_at = 0;
    bit oe_prev = 0;

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        logic [23:0] off;
        logic [15:0] v;
        off = a - BASE;
        if (off >= 24'(N)) return 16'hDEAD;
        v = mem_arr[off[LEN_LOG2-1:0]];
        if (fault_en && a == FAULT_ADDR) v = v | 16'h0008;
        return v;
    endfunction

    always @(negedge clk) begin
        logic [23:0] off;
        off = mem_bus.mem_addr - BASE;
        if (mem_bus.mem_we && off < 24'(N)) begin
            if (mem_bus.mem_uds) mem_arr[off[LEN_LOG2-1:0]][15:8] = mem_bus.mem_wdata[15:8];
            if (mem_bus.mem_lds) mem_arr[off[LEN_LOG2-1:0]][7:0]  = mem_bus.mem_wdata[7:0];
        end
        if (mem_bus.mem_oe) begin
            if (!oe_prev) begin
                oe_cnt = 0;
                if (slow_ack)          ack_at = 60;
                else if (refresh_mode) ack_at = int'($urandom_range(MIN_READ_WAIT + 1, 30));
                else                   ack_at = int'($urandom_range(1, 30));
            end else begin
                oe_cnt++;
            end
            if (oe_cnt >= ack_at) begin
                mem_bus.mem_dtack = 1'b1;
                mem_bus.mem_rdata = mem_word(mem_bus.mem_addr);
            end else begin
                // A refresh in progress shows a stale dtack with garbage data.
                mem_bus.mem_dtack = refresh_mode && oe_cnt >= 1 && oe_cnt <= 3;
                mem_bus.mem_rdata = 16'($urandom);
            end
        end else begin
            mem_bus.mem_dtack = 1'b0;
            mem_bus.mem_rdata = 16'($urandom);
        end
        oe_prev = mem_bus.mem_oe;
    end

    // ---------------- scoreboard ----------------
    acc_t        exp_q[$];
    acc_t        cur;
    bit          chk_en = 0, cur_valid = 0, first_acc = 1, prev_acc = 0;
    int          k = 0, stb_cnt = 0, gap_cnt = 0;
    int          m_err = 0, done_count = 0, we_pulses = 0, oe_pulses = 0;
    logic [23:0] m_addr = '0;
    logic [15:0] m_data = '0, m_exp = '0, first_wdata = '0;
    bit          have_wdata = 0;

    function automatic logic [15:0] pat(input logic [23:0] a);
        return a[15:0] ^ {8'h00, a[23:16]};
    endfunction

    task automatic build_queue();
        acc_t e;
        exp_q.delete();
        for (int ph = 0; ph < 2; ph++)
            for (int rd = 0; rd < 2; rd++)
                for (int i = 0; i < N; i++) begin
                    e.is_read = (rd == 1);
                    e.addr    = BASE + 24'(i);
                    e.data    = (ph == 1) ? ~pat(e.addr) : pat(e.addr);
                    e.uds     = 1;
                    e.lds     = 1;
                    exp_q.push_back(e);
                end
`ifdef SDRAM_BIST_BYTE_LANE_EN
        for (int i = 0; i < N; i++) begin
            e.addr = BASE + 24'(i);
            e.is_read = 0; e.data = 16'hA500; e.uds = 1; e.lds = 0; exp_q.push_back(e);
            e.is_read = 0; e.data = 16'h005A; e.uds = 0; e.lds = 1; exp_q.push_back(e);
            e.is_read = 1; e.data = 16'hA55A; e.uds = 1; e.lds = 1; exp_q.push_back(e);
        end
`endif
        m_err = 0; m_addr = '0; m_data = '0; m_exp = '0;
        we_pulses = 0; oe_pulses = 0; have_wdata = 0;
        first_acc = 1; cur_valid = 0;
    endtask

    // Per-cycle checks of every access against the expected transaction list.
    always @(negedge clk) begin
        logic        acc;
        logic [15:0] rv;
        acc = mem_bus.mem_we | mem_bus.mem_oe;
        if (chk_en) begin
            chk("oe_we_exclusive", 32'(mem_bus.mem_we & mem_bus.mem_oe), 0);
            if (acc) chk("busy_during_access", 32'(busy), 1);
            if (acc && !prev_acc) begin
                if (!first_acc) chk("gap_cycles", 32'(gap_cnt), GAP);
                first_acc = 0; k = 0; stb_cnt = 0;
                if (exp_q.size() == 0) begin
                    chk("extra_access", 32'(acc), 0);
                    cur_valid = 0;
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1;
                    chk("access_kind", 32'(mem_bus.mem_oe), 32'(cur.is_read));
                    chk("access_addr", 32'(mem_bus.mem_addr), 32'(cur.addr));
                    if (mem_bus.mem_oe) begin
                        oe_pulses++;
                        chk("read_strobes", 32'({mem_bus.mem_uds, mem_bus.mem_lds}), 3);
                        rv = mem_word(mem_bus.mem_addr);
                        if (rv !== cur.data) begin
                            if (m_err == 0) begin
                                m_addr = cur.addr; m_data = rv; m_exp = cur.data;
                            end
                            if (m_err < 65535) m_err++;
                        end
                    end else begin
                        we_pulses++;
                        if (!have_wdata) begin first_wdata = mem_bus.mem_wdata; have_wdata = 1; end
                        chk("write_data", 32'(mem_bus.mem_wdata), 32'(cur.data));
                        chk("write_req_strobes", 32'({mem_bus.mem_uds, mem_bus.mem_lds}), 0);
                    end
                end
            end else if (acc && cur_valid) begin
                k++;
                chk("addr_stable", 32'(mem_bus.mem_addr), 32'(cur.addr));
                if (cur.is_read) begin
                    chk("read_strobes_held", 32'({mem_bus.mem_uds, mem_bus.mem_lds}), 3);
                end else begin
                    chk("write_strobes", 32'({mem_bus.mem_uds, mem_bus.mem_lds}), 32'({cur.uds, cur.lds}));
                    chk("wdata_stable", 32'(mem_bus.mem_wdata), 32'(cur.data));
                    stb_cnt++;
                end
            end else if (!acc && prev_acc && cur_valid) begin
                chk("strobes_released", 32'({mem_bus.mem_uds, mem_bus.mem_lds}), 0);
                if (cur.is_read)
                    chk("read_min_length", 32'(k + 1 > MIN_READ_WAIT + DATA_DELAY), 1);
                else
                    chk("write_hold_cycles", 32'(stb_cnt), WRITE_HOLD);
            end
            if (!acc) gap_cnt = prev_acc ? 1 : gap_cnt + 1;
        end
        if (done) begin
            done_count++;
            if (chk_en) begin
                chk("done_busy_low", 32'(busy), 0);
                chk("done_accesses_left", 32'(exp_q.size()), 0);
                chk("pass_flag", 32'(pass), 32'(m_err == 0));
                chk("err_count", 32'(err_count), 32'(m_err));
                chk("err_addr", 32'(err_addr), 32'(m_addr));
                chk("err_data", 32'(err_data), 32'(m_data));
                chk("err_exp", 32'(err_exp), 32'(m_exp));
            end
        end
        prev_acc = acc;
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(posedge clk); #1;
        build_queue();
        chk_en = 1;
        start  = 1;
        @(posedge clk); #1;
        start  = 0;
    endtask

    task automatic run_test(input bit pulse_busy);
        int base_done;
        bit ok;
        base_done = done_count;
        ok = 0;
        pulse_start();
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            if (done_count != base_done) begin ok = 1; break; end
            start = pulse_busy && busy && ($urandom_range(0, 7) == 0);
        end
        start = 0;
        if (!ok) chk("done_timeout", 32'(done_count), 32'(base_done + 1));
        chk_en = 0;
        repeat (30) @(posedge clk);
        #1;
        chk("single_done_pulse", 32'(done_count), 32'(base_done + 1));
        chk("idle_after_done", 32'(busy), 0);
    endtask

    initial begin
        int dc;
        bit seen;
        for (int i = 0; i < N; i++) mem_arr[i] = 16'($urandom);
        mem_bus.mem_dtack = 1'b0;
        mem_bus.mem_rdata = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_err_addr", 32'(err_addr), 0);
        chk("rst_err_data", 32'(err_data), 0);
        chk("rst_err_exp", 32'(err_exp), 0);
        chk("rst_strobes_req", 32'({mem_bus.mem_oe, mem_bus.mem_we, mem_bus.mem_uds, mem_bus.mem_lds}), 0);
        chk("rst_mem_addr", 32'(mem_bus.mem_addr), 32'(BASE));
        chk("rst_mem_wdata", 32'(mem_bus.mem_wdata), 0);
        @(posedge clk); #1 reset = 0;

        // Ideal controller with random ack latency.
        run_test(0);
        chk("first_wdata_literal", 32'(first_wdata), 32'h0000FFFB);
        chk("pass_literal", 32'(pass), 1);
`ifndef SDRAM_BIST_BYTE_LANE_EN
        chk("we_pulses", 32'(we_pulses), 32);
        chk("oe_pulses", 32'(oe_pulses), 32);
`endif

        // Refresh coinciding with every oe rise, plus start pulses while busy.
        refresh_mode = 1;
        run_test(1);
        chk("refresh_pass", 32'(pass), 1);
        refresh_mode = 0;

        // Bit 3 stuck at 1 in one word: only the phase-0 read can miscompare.
        fault_en = 1;
        run_test(0);
        chk("fault_pass", 32'(pass), 0);
        chk("fault_err_count", 32'(err_count), 1);
        chk("fault_err_addr", 32'(err_addr), 32'h00020000);
        chk("fault_err_data", 32'(err_data), 32'h0000000A);
        chk("fault_err_exp", 32'(err_exp), 32'h00000002);
        fault_en = 0;

        // Reset during the third cycle of waiting for dtack.
        slow_ack = 1;
        pulse_start();
        seen = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (mem_bus.mem_oe) begin seen = 1; break; end
        end
        if (!seen) chk("first_read_timeout", 32'(mem_bus.mem_oe), 1);
        repeat (1 + MIN_READ_WAIT + 2) @(posedge clk);
        #1 reset = 1;
        chk_en = 0;
        dc = done_count;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("midrst_oe", 32'(mem_bus.mem_oe), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_strobes", 32'({mem_bus.mem_uds, mem_bus.mem_lds}), 0);
        chk("midrst_addr", 32'(mem_bus.mem_addr), 32'(BASE));
        repeat (100) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_count), 32'(dc));
        slow_ack = 0;
        run_test(0);
        chk("restart_pass", 32'(pass), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
